// File: rtl/shift_pipe.sv
// shift_pipe: two-stage pipelined ARM-style barrel shifter with valid/ready handshake and tag passthrough
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : input handshake (in_ready = stage 1 can advance)
//   SHIFT_OP, Shift_Data,
//   Shift_Num, Carry_flag    : operation, operand, amount, current C flag
//   in_tag / out_tag         : opaque tag returned with its result
//   out_valid/out_ready      : output handshake
//   Shift_Out, Shift_Carry_Out : result and shifter carry-out, driven from stage-2 registers
module shift_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       SHIFT_OP,
   input  logic [WIDTH-1:0] Shift_Data,
   input  logic [7:0]       Shift_Num,
   input  logic             Carry_flag,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Shift_Out,
   output logic             Shift_Carry_Out,
   output logic [TAG_W-1:0] out_tag
);
   localparam int LW = $clog2(WIDTH);
   localparam int AW = LW + 1;
   localparam logic [AW-1:0] AMT_W = AW'(WIDTH);
   typedef enum logic [2:0] {K_PASS, K_LSL, K_LSR, K_ASR, K_ROR, K_RRX, K_ZERO} kind_t;
   logic             s1_valid_q, s2_valid_q, s1_en, s2_en;
   kind_t            op_kind, kind_d, kind_q;
   logic [AW-1:0]    amt_d, amt_q;
   logic [LW-1:0]    n_lo, lo_idx, hi_idx;
   logic [WIDTH-1:0] d_q, out_d, out_q, rot_w;
   logic signed [WIDTH-1:0] asr_w;
   logic             c_q, carry_d, carry_q;
   logic [TAG_W-1:0] tag1_q, tag2_q;
   assign s2_en = !s2_valid_q || out_ready;
   assign s1_en = !s1_valid_q || s2_en;
   assign in_ready = s1_en;
   assign out_valid = s2_valid_q;
   assign Shift_Out = out_q;
   assign Shift_Carry_Out = carry_q;
   assign out_tag = tag2_q;
   assign n_lo = Shift_Num[LW-1:0];
   assign op_kind = kind_t'(3'(SHIFT_OP[2:1]) + 3'd1);
   // Every shift is normalised to an amount in 1..W so that the #0/#W special
   // cases collapse into the general formulas (carry = D[n-1] or D[W-n]).
   always_comb begin
      kind_d = K_PASS;
      amt_d = AMT_W;
      if (!SHIFT_OP[0]) begin
         if (n_lo == '0)
            kind_d = (SHIFT_OP[2:1] == 2'd0) ? K_PASS : (SHIFT_OP[2:1] == 2'd3) ? K_RRX : op_kind;
         else begin
            kind_d = op_kind;
            amt_d = AW'(n_lo);
         end
      end else if (Shift_Num != 8'd0) begin
         kind_d = op_kind;
         case (SHIFT_OP[2:1])
            2'd0, 2'd1: if (Shift_Num > 8'(WIDTH)) kind_d = K_ZERO; else amt_d = Shift_Num[LW:0];
            2'd2: if (Shift_Num < 8'(WIDTH)) amt_d = Shift_Num[LW:0];
            default: if (n_lo != '0) amt_d = AW'(n_lo);
         endcase
      end
   end
   // Rotate by W (register ROR with m = 0) yields D and carry D[W-1], matching the general path.
   assign rot_w = (d_q >> amt_q) | (d_q << (AMT_W - amt_q));
   assign asr_w = $signed(d_q) >>> amt_q;
   assign lo_idx = LW'(amt_q - AW'(1));
   assign hi_idx = LW'(AMT_W - amt_q);
   always_comb begin
      out_d = (kind_q == K_LSL) ? d_q << amt_q :
              (kind_q == K_LSR) ? d_q >> amt_q :
              (kind_q == K_ASR) ? asr_w :
              (kind_q == K_ROR) ? rot_w :
              (kind_q == K_RRX) ? {c_q, d_q[WIDTH-1:1]} :
              (kind_q == K_ZERO) ? '0 : d_q;
      carry_d = (kind_q == K_LSL) ? d_q[hi_idx] :
                (kind_q == K_LSR || kind_q == K_ASR || kind_q == K_ROR) ? d_q[lo_idx] :
                (kind_q == K_RRX) ? d_q[0] :
                (kind_q == K_ZERO) ? 1'b0 : c_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         kind_q <= K_PASS;
         amt_q <= AMT_W;
         d_q <= '0;
         c_q <= 1'b0;
         tag1_q <= '0;
         out_q <= '0;
         carry_q <= 1'b0;
         tag2_q <= '0;
      end else begin
         if (s1_en) s1_valid_q <= in_valid;
         if (s1_en && in_valid) begin
            kind_q <= kind_d;
            amt_q <= amt_d;
            d_q <= Shift_Data;
            c_q <= Carry_flag;
            tag1_q <= in_tag;
         end
         if (s2_en) s2_valid_q <= s1_valid_q;
         if (s2_en && s1_valid_q) begin
            out_q <= out_d;
            carry_q <= carry_d;
            tag2_q <= tag1_q;
         end
      end
   end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: scoreboard bench for shift_pipe at WIDTH=32 and WIDTH=16
module tb_shift_pipe;
   typedef struct {
      logic [3:0]  tag;
      logic [31:0] out;
      logic        c;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst;
   logic        a_in_valid, a_in_ready, a_c, a_out_valid, a_out_ready, a_cout;
   logic [2:0]  a_op;
   logic [7:0]  a_num;
   logic [31:0] a_d, a_out;
   logic [3:0]  a_tag, a_otag;
   logic        b_in_valid, b_in_ready, b_c, b_out_valid, b_out_ready, b_cout;
   logic [2:0]  b_op;
   logic [7:0]  b_num;
   logic [15:0] b_d, b_out;
   logic [3:0]  b_tag, b_otag;
   exp_t        qa[$], qb[$];
   int          checks = 0, failures = 0;
   always #5 clk = ~clk;
   shift_pipe #(.WIDTH(32), .TAG_W(4)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .SHIFT_OP(a_op), .Shift_Data(a_d), .Shift_Num(a_num), .Carry_flag(a_c), .in_tag(a_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .Shift_Out(a_out),
      .Shift_Carry_Out(a_cout), .out_tag(a_otag)
   );
   shift_pipe #(.WIDTH(16), .TAG_W(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .SHIFT_OP(b_op), .Shift_Data(b_d), .Shift_Num(b_num), .Carry_flag(b_c), .in_tag(b_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .Shift_Out(b_out),
      .Shift_Carry_Out(b_cout), .out_tag(b_otag)
   );
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!rst && a_out_valid && a_out_ready) begin
         if (qa.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_output actual_tag=%0h required=none", a_otag);
         end else begin
            exp_t e;
            e = qa.pop_front();
            check("a_tag", a_otag, e.tag);
            check("a_out", a_out, e.out);
            check("a_carry", a_cout, e.c);
         end
      end
   end
   always @(negedge clk) begin
      if (!rst && b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_output actual_tag=%0h required=none", b_otag);
         end else begin
            exp_t e;
            e = qb.pop_front();
            check("b_tag", b_otag, e.tag);
            check("b_out", b_out, e.out[15:0]);
            check("b_carry", b_cout, e.c);
         end
      end
   end
   task automatic send_a(input logic [2:0] op, input logic [7:0] num, input logic [31:0] d,
                         input logic c, input logic [3:0] tag, input logic [31:0] eo, input logic ec);
      int n = 0;
      a_op = op; a_num = num; a_d = d; a_c = c; a_tag = tag; a_in_valid = 1'b1;
      while (!a_in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!a_in_ready) begin
         checks++;
         failures++;
         $display("FAIL a_accept_timeout actual_in_ready=0 required=1");
      end else qa.push_back('{tag: tag, out: eo, c: ec});
      @(posedge clk); #1;
      a_in_valid = 1'b0;
   endtask
   task automatic send_b(input logic [2:0] op, input logic [7:0] num, input logic [15:0] d,
                         input logic c, input logic [3:0] tag, input logic [15:0] eo, input logic ec);
      int n = 0;
      b_op = op; b_num = num; b_d = d; b_c = c; b_tag = tag; b_in_valid = 1'b1;
      while (!b_in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!b_in_ready) begin
         checks++;
         failures++;
         $display("FAIL b_accept_timeout actual_in_ready=0 required=1");
      end else qb.push_back('{tag: tag, out: {16'h0, eo}, c: ec});
      @(posedge clk); #1;
      b_in_valid = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_pending", qa.size() + qb.size(), 0);
   endtask
   initial begin
      rst = 1'b1;
      a_in_valid = 1'b0; a_out_ready = 1'b1; a_op = '0; a_num = '0; a_d = '0; a_c = 1'b0; a_tag = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_op = '0; b_num = '0; b_d = '0; b_c = 1'b0; b_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_out_valid", a_out_valid, 0);
      check("rst_a_out", a_out, 0);
      check("rst_a_carry", a_cout, 0);
      check("rst_a_tag", a_otag, 0);
      check("rst_b_out_valid", b_out_valid, 0);
      rst = 1'b0;
      #1;
      check("rst_a_in_ready", a_in_ready, 1);
      send_a(3'b001, 8'd3,  32'h3ac50001, 1'b0, 4'h5, 32'hd6280008, 1'b1);
      send_a(3'b010, 8'd0,  32'hf0000000, 1'b0, 4'h6, 32'h00000000, 1'b1);
      send_a(3'b110, 8'd0,  32'h999ff999, 1'b1, 4'h7, 32'hcccffccc, 1'b1);
      send_a(3'b000, 8'd35, 32'h3ac50001, 1'b0, 4'h8, 32'hd6280008, 1'b1);
      send_a(3'b101, 8'd33, 32'hffffffff, 1'b0, 4'h9, 32'hffffffff, 1'b1);
      send_a(3'b011, 8'd32, 32'h80000000, 1'b0, 4'ha, 32'h00000000, 1'b1);
      send_a(3'b111, 8'd39, 32'h1f2f3f4f, 1'b0, 4'hb, 32'h9e3e5e7e, 1'b1);
      send_a(3'b111, 8'd32, 32'h8a9d029d, 1'b0, 4'hc, 32'h8a9d029d, 1'b1);
      send_a(3'b001, 8'd40, 32'hffffffff, 1'b1, 4'hd, 32'h00000000, 1'b0);
      send_a(3'b001, 8'd32, 32'h00000001, 1'b0, 4'he, 32'h00000000, 1'b1);
      send_a(3'b100, 8'd4,  32'h80000010, 1'b0, 4'hf, 32'hf8000001, 1'b0);
      send_a(3'b101, 8'd0,  32'h12345678, 1'b1, 4'h0, 32'h12345678, 1'b1);
      send_a(3'b000, 8'h20, 32'h0000abcd, 1'b0, 4'h1, 32'h0000abcd, 1'b0);
      send_a(3'b010, 8'd4,  32'h000000f8, 1'b1, 4'h2, 32'h0000000f, 1'b1);
      send_a(3'b110, 8'd8,  32'h12345678, 1'b0, 4'h3, 32'h78123456, 1'b0);
      send_a(3'b101, 8'd8,  32'h7f00ff80, 1'b0, 4'h4, 32'h007f00ff, 1'b1);
      send_a(3'b000, 8'd31, 32'h00000003, 1'b0, 4'h5, 32'h80000000, 1'b1);
      send_b(3'b011, 8'd16,  16'h8001, 1'b0, 4'h1, 16'h0000, 1'b1);
      send_b(3'b000, 8'h13,  16'h2001, 1'b0, 4'h2, 16'h0008, 1'b1);
      send_b(3'b100, 8'd0,   16'h8000, 1'b0, 4'h3, 16'hffff, 1'b1);
      send_b(3'b111, 8'd20,  16'h1234, 1'b0, 4'h4, 16'h4123, 1'b0);
      send_b(3'b001, 8'd17,  16'hffff, 1'b1, 4'h5, 16'h0000, 1'b0);
      drain();
      a_out_ready = 1'b0;
      send_a(3'b001, 8'd1, 32'h00000001, 1'b0, 4'h1, 32'h00000002, 1'b0);
      send_a(3'b010, 8'd1, 32'h00000004, 1'b0, 4'h2, 32'h00000002, 1'b0);
      check("bp_in_ready_low", a_in_ready, 0);
      check("bp_out_valid", a_out_valid, 1);
      a_op = 3'b111; a_num = 8'd4; a_d = 32'h0000000f; a_c = 1'b0; a_tag = 4'h3; a_in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_hold_in_ready", a_in_ready, 0);
         check("bp_hold_tag", a_otag, 4'h1);
         check("bp_hold_out", a_out, 32'h00000002);
         check("bp_hold_carry", a_cout, 0);
      end
      qa.push_back('{tag: 4'h3, out: 32'hf0000000, c: 1'b1});
      a_out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", a_in_ready, 1);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      drain();
      a_out_ready = 1'b0;
      send_a(3'b001, 8'd4, 32'h00000001, 1'b0, 4'h7, 32'h00000010, 1'b0);
      send_a(3'b011, 8'd4, 32'h00000100, 1'b0, 4'h8, 32'h00000010, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      qa.delete();
      rst = 1'b0;
      check("mid_rst_out_valid", a_out_valid, 0);
      check("mid_rst_out", a_out, 0);
      check("mid_rst_carry", a_cout, 0);
      check("mid_rst_tag", a_otag, 0);
      check("mid_rst_in_ready", a_in_ready, 1);
      a_out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_idle", a_out_valid, 0);
      send_a(3'b100, 8'd1, 32'h80000000, 1'b0, 4'h9, 32'hc0000000, 1'b0);
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
